// File: rtl/alu_pkg.sv
// Shared opcode constants, entry layout and helpers for the ALU result stage.
// The entry width is fixed here; the stage parameters default to these values.
package alu_pkg;

    localparam int unsigned ALU_DW     = 16;
    localparam int unsigned ALU_DEST_W = 4;
    localparam int unsigned ALU_OP_W   = 4;

    localparam logic [ALU_OP_W-1:0] OP_AND  = 4'd0;
    localparam logic [ALU_OP_W-1:0] OP_OR   = 4'd1;
    localparam logic [ALU_OP_W-1:0] OP_ADD  = 4'd2;
    localparam logic [ALU_OP_W-1:0] OP_SUB  = 4'd3;
    localparam logic [ALU_OP_W-1:0] OP_XOR  = 4'd4;
    localparam logic [ALU_OP_W-1:0] OP_NOR  = 4'd5;
    localparam logic [ALU_OP_W-1:0] OP_NAND = 4'd6;
    localparam logic [ALU_OP_W-1:0] OP_INV  = 4'd7;

    typedef struct packed {
        logic [ALU_DW-1:0]     result;
        logic                  zero;
        logic                  neg;
        logic                  ovfl;
        logic [ALU_OP_W-1:0]   op;
        logic [ALU_DEST_W-1:0] dest;
        logic                  wb_en;
    } alu_entry_t;

    function automatic logic is_arith(input logic [ALU_OP_W-1:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

    function automatic logic is_known_op(input logic [ALU_OP_W-1:0] op);
        return op <= OP_INV;
    endfunction

endpackage

// File: rtl/alu_skid_buf.sv
// Generic 2-entry valid/ready skid register; in_ready comes straight from a flop
// so there is no combinational path from out_ready back upstream.
module alu_skid_buf #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         main_valid_q, main_valid_d;
    logic         skid_valid_q, skid_valid_d;
    logic [W-1:0] main_q, main_d;
    logic [W-1:0] skid_q, skid_d;
    logic         in_xfer, out_xfer;

    assign in_ready  = !skid_valid_q;
    assign out_valid = main_valid_q;
    assign out_data  = main_q;
    assign in_xfer   = in_valid && !skid_valid_q;
    assign out_xfer  = main_valid_q && out_ready;

    always_comb begin
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        main_d       = main_q;
        skid_d       = skid_q;
        if (out_xfer) begin
            if (skid_valid_q) begin
                main_d       = skid_q;
                skid_valid_d = 1'b0;
            end else if (in_xfer) begin
                main_d = in_data;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (in_xfer) begin
            // skid only fills when main is occupied and stalled
            if (!main_valid_q) begin
                main_d       = in_data;
                main_valid_d = 1'b1;
            end else begin
                skid_d       = in_data;
                skid_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            main_q       <= '0;
            skid_q       <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            main_q       <= main_d;
            skid_q       <= skid_d;
        end
    end

endmodule

// File: rtl/alu_result_stage.sv
// ALU result register stage: skid-buffered handshake plus architectural Z/N/V flags.
// ALU_RESULT_SAT_EN saturates overflowing add/sub results at capture.
import alu_pkg::*;

module alu_result_stage #(
    parameter int unsigned DW     = ALU_DW,
    parameter int unsigned DEST_W = ALU_DEST_W,
    parameter int unsigned OP_W   = ALU_OP_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DW-1:0]     in_result,
    input  logic              in_zero,
    input  logic              in_neg,
    input  logic              in_ovfl,
    input  logic [OP_W-1:0]   in_op,
    input  logic [DEST_W-1:0] in_dest,
    input  logic              in_wb_en,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DW-1:0]     out_result,
    output logic [DEST_W-1:0] out_dest,
    output logic              out_wb_en,
    output logic              flag_z,
    output logic              flag_n,
    output logic              flag_v,
    output logic              bad_op
);

    localparam int unsigned EW = $bits(alu_entry_t);

    alu_entry_t    in_entry, main_e;
    logic [EW-1:0] main_bits;
    logic          out_xfer;
    logic          flag_z_q, flag_z_d;
    logic          flag_n_q, flag_n_d;
    logic          flag_v_q, flag_v_d;
    logic          bad_op_q, bad_op_d;

    always_comb begin
        in_entry.result = in_result;
        in_entry.zero   = in_zero;
        in_entry.neg    = in_neg;
        in_entry.ovfl   = in_ovfl;
        in_entry.op     = in_op;
        in_entry.dest   = in_dest;
        in_entry.wb_en  = in_wb_en;
`ifdef ALU_RESULT_SAT_EN
        // a wrapped sign bit means the true result went the other way
        if (is_arith(in_op) && in_ovfl) begin
            in_entry.result = in_result[DW-1] ? {1'b0, {(DW-1){1'b1}}}
                                              : {1'b1, {(DW-1){1'b0}}};
            in_entry.zero   = 1'b0;
            in_entry.neg    = in_entry.result[DW-1];
        end
`endif
    end

    alu_skid_buf #(.W(EW)) u_skid (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_entry),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (main_bits)
    );

    assign main_e     = alu_entry_t'(main_bits);
    assign out_result = main_e.result;
    assign out_dest   = main_e.dest;
    assign out_wb_en  = main_e.wb_en;
    assign out_xfer   = out_valid && out_ready;

    always_comb begin
        flag_z_d = flag_z_q;
        flag_n_d = flag_n_q;
        flag_v_d = flag_v_q;
        bad_op_d = 1'b0;
        if (out_xfer) begin
            if (is_known_op(main_e.op)) begin
                flag_z_d = main_e.zero;
                flag_n_d = main_e.neg;
                flag_v_d = is_arith(main_e.op) && main_e.ovfl;
            end else begin
                bad_op_d = 1'b1;
            end
        end
    end

    // flags and bad_op become visible the cycle after the retiring transfer
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flag_z_q <= 1'b0;
            flag_n_q <= 1'b0;
            flag_v_q <= 1'b0;
            bad_op_q <= 1'b0;
        end else begin
            flag_z_q <= flag_z_d;
            flag_n_q <= flag_n_d;
            flag_v_q <= flag_v_d;
            bad_op_q <= bad_op_d;
        end
    end

    assign flag_z = flag_z_q;
    assign flag_n = flag_n_q;
    assign flag_v = flag_v_q;
    assign bad_op = bad_op_q;

endmodule

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
- Pipeline stage directly downstream of the 16-bit ALU. It registers the ALU result, the zero/negative/overflow flags, and the writeback tag.
- A 2-entry skid buffer with valid/ready handshakes on both sides decouples the ALU from the memory/writeback stage.
- Holds the architectural status flags (Z/N/V) used by branch logic, updated when a result retires.

Parameters:
- DW, 16, datapath width of the result
- DEST_W, 4, register-file destination index width
- OP_W, 4, ALU opcode width

Ports:
- clk  input  1  single clock, all state on rising edge
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  ALU result present this cycle
- in_ready  output  1  stage can accept; registered output
- in_result  input  DW  ALU R (signed)
- in_zero  input  1  ALU isZero
- in_neg  input  1  ALU isNegative
- in_ovfl  input  1  ALU ovfl (meaningful only for op 2/3)
- in_op  input  OP_W  opcode that produced the result
- in_dest  input  DEST_W  writeback register index
- in_wb_en  input  1  result to be written back
- out_valid  output  1  entry available downstream
- out_ready  input  1  downstream accepts
- out_result  output  DW  registered result
- out_dest  output  DEST_W  registered dest
- out_wb_en  output  1  registered writeback enable
- flag_z  output  1  architectural zero flag
- flag_n  output  1  architectural negative flag
- flag_v  output  1  architectural overflow flag
- bad_op  output  1  one-cycle pulse when a retired entry carried op > 7

Behaviour:
- Reset (asynchronous, mid-operation included): both entries invalid; out_valid=0, in_ready=1, out_result=0, out_dest=0, out_wb_en=0, flag_z=0, flag_n=0, flag_v=0, bad_op=0. Any in-flight data is discarded.
- Storage: a main register drives the outputs; a skid register absorbs one beat when out_ready drops.
- Input transfer: in_valid && in_ready. Output transfer: out_valid && out_ready.
- in_ready = !skid_valid, registered. It depends on no combinational path from out_ready.
- State is {main_valid, skid_valid}:
  - EMPTY (0,0): an input transfer loads main; next state is ONE.
  - ONE (1,0):
    - input only: load skid; next state FULL.
    - output only: next state EMPTY.
    - input and output in the same cycle: reload main; stay ONE.
  - FULL (1,1), in_ready=0:
    - output transfer: skid moves to main; next state ONE.
  - A skid entry is never overwritten.
- Latency: 1 cycle from input transfer to out_valid when the stage is empty. Throughput is 1 per cycle while out_ready=1.
- Order is strict FIFO. out_* fields are stable while out_valid && !out_ready.
- Flags: on each output transfer with op 0..7:
  - flag_z and flag_n are loaded from the stored zero/neg of that entry.
  - flag_v is loaded from the stored ovfl for op 2/3, and cleared for other ops.
  - Flags hold otherwise.
- op 8..15 on an output transfer: the data is still delivered, flags hold, and bad_op pulses high for exactly that cycle.
- Stored zero/neg are taken from the ALU ports. This stage does not recompute them, except under SAT_EN.

Optional Feature:
- Macro: ALU_RESULT_SAT_EN.
- When defined: at input capture, if op is 2 or 3 and in_ovfl=1, the stored result saturates.
  - 16'h7FFF if in_result[15]=1 (positive overflow wrapped negative).
  - 16'h8000 if in_result[15]=0.
  - Stored zero is set to 0, stored neg is set to the saturated result's sign bit, and stored ovfl stays 1.
- When undefined: the result passes through unmodified (wrap-around).
- The handshake and flag timing are identical in both builds.

Decomposition:
- Shared package alu_pkg:
  - opcode constants OP_AND=0, OP_OR=1, OP_ADD=2, OP_SUB=3, OP_XOR=4, OP_NOR=5, OP_NAND=6, OP_INV=7
  - a function is_arith(op)
  - a packed entry typedef {result, zero, neg, ovfl, op, dest, wb_en}
- One natural sub-module: alu_skid_buf, a generic 2-entry valid/ready skid register parameterised on entry width. The top level adds flag logic and saturation.

Test Plan:
- Reset, then in_result=16'h0000, in_zero=1, op=0 accepted with out_ready=1: out_valid=1 next cycle, out_result=0, and on transfer flag_z=1, flag_n=0, flag_v=0.
- Back-to-back 4 beats (16'h0001..16'h0004) with out_ready=1: one output per cycle, in order, in_ready never drops.
- out_ready=0 while pushing 3 beats: in_ready falls after the 2nd accept and the 3rd is held off. Raising out_ready delivers beats 1, 2, 3 in order, and out fields stay stable while stalled.
- op=2, in_result=16'h8000, in_ovfl=1, in_neg=1:
  - without macro: out_result=16'h8000, flag_v=1, flag_n=1.
  - with ALU_RESULT_SAT_EN: out_result=16'h7FFF, flag_n=0, flag_v=1.
- op=9 retired after flags Z=1: data delivered, bad_op pulses 1 cycle, flags unchanged. A following op=4 with in_neg=1 then sets flag_n=1 and clears flag_v.
- Assert reset while FULL with out_ready=0: out_valid=0 and in_ready=1 immediately (asynchronous), flags 0, and no stale beat appears after release.
